// File: rtl/l2_burst_pkg.sv
// Shared types and default geometry for the L2 burst responder.
// States, default widths and the beats-per-line helper live here.
package l2_burst_pkg;

  localparam int unsigned DefOffset = 5;
  localparam int unsigned DefLine   = 256;
  localparam int unsigned DefBeat   = 64;
  localparam int unsigned Beats     = DefLine / DefBeat;

  typedef enum logic [1:0] {
    StIdle,
    StRdBurst,
    StWrBurst,
    StResp
  } state_e;

  // Beats per line for a given line/beat width pair.
  function automatic int unsigned beats_of(input int unsigned line_w, input int unsigned beat_w);
    return line_w / beat_w;
  endfunction

endpackage

// File: rtl/l2_burst_responder_if.sv
// Cache-side and physical-memory-side bus of the L2 burst responder.
// master: arbiter + memory environment; slave: the responder.
interface l2_burst_responder_if
  import l2_burst_pkg::*;
#(
  parameter int unsigned s_line = DefLine,
  parameter int unsigned s_beat = DefBeat
);
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_address;
  logic [s_line-1:0] mem_wdata;
  logic              mem_resp;
  logic [s_line-1:0] mem_rdata;

  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [s_beat-1:0] pmem_wdata;
  logic [s_beat-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_resp, mem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_resp, mem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/l2_burst_responder_line_assembler.sv
// line_assembler: line register filled one beat at a time.
// A load writes beat_data into slice beat_idx; other beats hold.
module line_assembler #(
  parameter int unsigned s_line = 256,
  parameter int unsigned s_beat = 64,
  parameter int unsigned beat_w = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [beat_w-1:0] beat_idx,
  input  logic [s_beat-1:0] beat_data,
  output logic [s_line-1:0] line
);

  logic [s_line-1:0] line_q;

  // Per-beat write of the assembled line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (load) begin
      line_q[beat_idx*s_beat +: s_beat] <= beat_data;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/l2_burst_responder.sv
// l2_burst_responder: turns cache line read/write requests into beat
// bursts on physical memory and returns a one-cycle mem_resp.
// Optional feature macro: L2_LINE_BUFFER_EN (last-line buffer, read hits
// answered without a pmem burst).
module l2_burst_responder
  import l2_burst_pkg::*;
#(
  parameter int unsigned s_offset = DefOffset,
  parameter int unsigned s_line   = DefLine,
  parameter int unsigned s_beat   = DefBeat
) (
  input logic                 clk,
  input logic                 rst_n,
  l2_burst_responder_if.slave bus
);

  localparam int unsigned NumBeats = beats_of(s_line, s_beat);
  localparam int unsigned BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(NumBeats - 1);

  state_e            state_q;
  logic [BeatW-1:0]  beat_q;
  logic [31:0]       addr_q;
  logic [s_line-1:0] wline_q;
  logic              pmem_read_q;
  logic              pmem_write_q;
  logic              mem_resp_q;
  logic [s_line-1:0] asm_line;
  logic              asm_load;
  logic              last_beat;
  logic [31:0]       req_addr;

  assign req_addr  = {bus.mem_address[31:s_offset], {s_offset{1'b0}}};
  assign last_beat = bus.pmem_resp && (beat_q == LastBeat);
  assign asm_load  = (state_q == StRdBurst) && bus.pmem_resp;

`ifdef L2_LINE_BUFFER_EN
  logic                valid_q;
  logic [31-s_offset:0] tag_q;
  logic [s_line-1:0]   buf_q;
  logic                sel_buf_q;
  logic                hit;
  logic [s_line-1:0]   merged_line;

  assign hit = valid_q && (tag_q == bus.mem_address[31:s_offset]);

  // Line as it will look once the final beat lands.
  always_comb begin
    merged_line = asm_line;
    merged_line[(NumBeats-1)*s_beat +: s_beat] = bus.pmem_rdata;
  end

  // Track the last line read or written and which copy drives mem_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      tag_q     <= '0;
      buf_q     <= '0;
      sel_buf_q <= 1'b0;
    end else begin
      if (state_q == StRdBurst && last_beat) begin
        valid_q   <= 1'b1;
        tag_q     <= addr_q[31:s_offset];
        buf_q     <= merged_line;
        sel_buf_q <= 1'b0;
      end else if (state_q == StWrBurst && last_beat) begin
        valid_q <= 1'b1;
        tag_q   <= addr_q[31:s_offset];
        buf_q   <= wline_q;
      end else if (state_q == StIdle && !bus.mem_write && bus.mem_read && hit) begin
        sel_buf_q <= 1'b1;
      end
    end
  end

  assign bus.mem_rdata = sel_buf_q ? buf_q : asm_line;
`else
  assign bus.mem_rdata = asm_line;
`endif

  // Burst sequencer; all bus outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      beat_q       <= '0;
      addr_q       <= '0;
      wline_q      <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      mem_resp_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          beat_q <= '0;
          // Write wins when both requests are raised together.
          if (bus.mem_write) begin
            addr_q       <= req_addr;
            wline_q      <= bus.mem_wdata;
            pmem_write_q <= 1'b1;
            state_q      <= StWrBurst;
          end else if (bus.mem_read) begin
`ifdef L2_LINE_BUFFER_EN
            if (hit) begin
              mem_resp_q <= 1'b1;
              state_q    <= StResp;
            end else
`endif
            begin
              addr_q      <= req_addr;
              pmem_read_q <= 1'b1;
              state_q     <= StRdBurst;
            end
          end
        end
        StRdBurst, StWrBurst: begin
          if (bus.pmem_resp) begin
            if (last_beat) begin
              beat_q       <= '0;
              pmem_read_q  <= 1'b0;
              pmem_write_q <= 1'b0;
              mem_resp_q   <= 1'b1;
              state_q      <= StResp;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        StResp: begin
          mem_resp_q <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  line_assembler #(
    .s_line (s_line),
    .s_beat (s_beat),
    .beat_w (BeatW)
  ) u_line_assembler (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (asm_load),
    .beat_idx  (beat_q),
    .beat_data (bus.pmem_rdata),
    .line      (asm_line)
  );

  assign bus.mem_resp     = mem_resp_q;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wline_q[beat_q*s_beat +: s_beat];

endmodule

// File: tb/tb_l2_burst_responder.sv
// Directed bench for l2_burst_responder (default 256-bit line, 64-bit beats).
// The memory model answers one cycle after it first sees a burst request.
module tb_l2_burst_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  l2_burst_responder_if #(.s_line(256), .s_beat(64)) bus ();

  l2_burst_responder #(
    .s_offset (5),
    .s_line   (256),
    .s_beat   (64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [63:0]  rbeat [4];
  int           waits [4];
  logic [63:0]  wseen [4];
  int           lat;
  int           resp_cnt;
  int           hold_err;
  int           addr_err;
  logic         saw_r;
  logic         saw_w;
  logic [255:0] rdata_seen;

  localparam logic [255:0] LineA = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] LineW = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
                                    64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};

  // Drive one request and act as physical memory until mem_resp (bounded).
  task automatic do_burst(input logic is_rd, input logic is_wr, input logic [31:0] addr,
                          input logic [255:0] wline, input logic [31:0] exp_addr);
    int beat;
    int wait_left;
    logic seen_active;
    logic active;
    beat = 0; wait_left = waits[0]; seen_active = 1'b0;
    lat = -1; resp_cnt = 0; hold_err = 0; addr_err = 0;
    saw_r = 1'b0; saw_w = 1'b0; rdata_seen = '0;
    for (int k = 0; k < 4; k++) wseen[k] = '0;
    @(posedge clk); #1;
    bus.mem_read = is_rd; bus.mem_write = is_wr;
    bus.mem_address = addr; bus.mem_wdata = wline;
    for (int cyc = 1; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      bus.pmem_resp = 1'b0;
      if (bus.mem_resp) begin
        resp_cnt++;
        if (lat < 0) lat = cyc;
        rdata_seen = bus.mem_rdata;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      end
      if (bus.pmem_read) saw_r = 1'b1;
      if (bus.pmem_write) saw_w = 1'b1;
      active = bus.pmem_read | bus.pmem_write;
      if (active && bus.pmem_address !== exp_addr) addr_err++;
      if (seen_active && beat < 4) begin
        if (!active) hold_err++;
        if (wait_left > 0) begin
          wait_left--;
        end else begin
          bus.pmem_resp = 1'b1;
          bus.pmem_rdata = rbeat[beat];
          wseen[beat] = bus.pmem_wdata;
          beat++;
          if (beat < 4) wait_left = waits[beat];
        end
      end
      if (active) seen_active = 1'b1;
      if (lat >= 0 && cyc > lat + 2) break;
    end
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.pmem_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.mem_resp, bus.pmem_read, bus.pmem_write} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000", {bus.mem_resp, bus.pmem_read, bus.pmem_write});
    end
    checks++;
    if (bus.pmem_address !== 32'h0 || bus.mem_rdata !== 256'h0) begin
      failures++;
      $display("FAIL reset_data addr=%h rdata=%h exp=0", bus.pmem_address, bus.mem_rdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    rbeat[0] = LineA[63:0];    rbeat[1] = LineA[127:64];
    rbeat[2] = LineA[191:128]; rbeat[3] = LineA[255:192];
    for (int k = 0; k < 4; k++) waits[k] = 0;
    do_burst(1'b1, 1'b0, 32'h0000_1234, '0, 32'h0000_1220);
    checks++;
    if (lat !== 6) begin failures++; $display("FAIL rd_latency got=%0d exp=6", lat); end
    checks++;
    if (rdata_seen !== LineA) begin
      failures++; $display("FAIL rd_data got=%h exp=%h", rdata_seen, LineA);
    end
    checks++;
    if (addr_err !== 0 || hold_err !== 0 || !saw_r) begin
      failures++;
      $display("FAIL rd_bus addr_err=%0d hold_err=%0d saw_r=%b exp=0,0,1", addr_err, hold_err,
               saw_r);
    end
    checks++;
    if (resp_cnt !== 1) begin failures++; $display("FAIL rd_resp_cnt got=%0d exp=1", resp_cnt); end
  endtask

`ifdef L2_LINE_BUFFER_EN
  task automatic test_line_buffer_hit();
    do_burst(1'b1, 1'b0, 32'h0000_1220, '0, 32'h0000_1220);
    checks++;
    if (lat !== 1 || saw_r !== 1'b0) begin
      failures++; $display("FAIL hit got lat=%0d saw_r=%b exp lat=1 saw_r=0", lat, saw_r);
    end
    checks++;
    if (rdata_seen !== LineA) begin
      failures++; $display("FAIL hit_data got=%h exp=%h", rdata_seen, LineA);
    end
  endtask
`endif

  task automatic test_stray_resp();
    int bad;
    bad = 0;
    @(posedge clk); #1;
    bus.pmem_resp = 1'b1; bus.pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.mem_resp || bus.pmem_read || bus.pmem_write) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad !== 0 || bus.mem_rdata !== LineA) begin
      failures++; $display("FAIL stray_resp bad=%0d rdata=%h exp=0,%h", bad, bus.mem_rdata, LineA);
    end
  endtask

  task automatic test_write();
    for (int k = 0; k < 4; k++) waits[k] = 0;
    do_burst(1'b0, 1'b1, 32'h0000_0040, LineW, 32'h0000_0040);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wseen[k] !== LineW[k*64 +: 64]) begin
        failures++; $display("FAIL wr_beat%0d got=%h exp=%h", k, wseen[k], LineW[k*64 +: 64]);
      end
    end
    checks++;
    if (resp_cnt !== 1 || lat !== 6 || saw_r || !saw_w || addr_err !== 0 || hold_err !== 0) begin
      failures++;
      $display("FAIL wr_ctrl resp=%0d lat=%0d r=%b w=%b ae=%0d he=%0d exp 1,6,0,1,0,0", resp_cnt,
               lat, saw_r, saw_w, addr_err, hold_err);
    end
    // Read line must survive a write.
    checks++;
    if (bus.mem_rdata !== LineA) begin
      failures++; $display("FAIL rdata_hold got=%h exp=%h", bus.mem_rdata, LineA);
    end
  endtask

  task automatic test_both_high();
    for (int k = 0; k < 4; k++) waits[k] = 0;
    do_burst(1'b1, 1'b1, 32'h0000_0084, LineW, 32'h0000_0080);
    checks++;
    if (saw_r !== 1'b0 || saw_w !== 1'b1 || resp_cnt !== 1 || addr_err !== 0) begin
      failures++;
      $display("FAIL both_high r=%b w=%b resp=%0d ae=%0d exp 0,1,1,0", saw_r, saw_w, resp_cnt,
               addr_err);
    end
  endtask

  task automatic test_wait_states();
    logic [255:0] exp_line;
    exp_line = {64'hA4, 64'hA3, 64'hA2, 64'hA1};
    rbeat[0] = 64'hA1; rbeat[1] = 64'hA2; rbeat[2] = 64'hA3; rbeat[3] = 64'hA4;
    waits[0] = 2; waits[1] = 0; waits[2] = 3; waits[3] = 1;
    do_burst(1'b1, 1'b0, 32'h0000_3000, '0, 32'h0000_3000);
    checks++;
    if (rdata_seen !== exp_line || resp_cnt !== 1) begin
      failures++;
      $display("FAIL wait_states data=%h resp=%0d exp=%h,1", rdata_seen, resp_cnt, exp_line);
    end
    checks++;
    if (lat !== 12 || hold_err !== 0) begin
      failures++; $display("FAIL wait_latency lat=%0d he=%0d exp 12,0", lat, hold_err);
    end
  endtask

  task automatic test_reset_mid_burst();
    int resps;
    logic [255:0] exp_line;
    resps = 0;
    @(posedge clk); #1;
    bus.mem_read = 1'b1; bus.mem_address = 32'h0000_5000;
    // cycle 1: pmem_read seen; cycles 2..4: beats 0..2 offered
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk); #1;
      if (bus.mem_resp) resps++;
      bus.pmem_resp = (cyc >= 2);
      bus.pmem_rdata = 64'hBB00 + 64'(cyc);
    end
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pmem_read !== 1'b0 || bus.pmem_address !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset pmem_read=%b addr=%h exp=0,0", bus.pmem_read, bus.pmem_address);
    end
    bus.mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.mem_resp || bus.pmem_read) resps++;
    end
    checks++;
    if (resps !== 0) begin failures++; $display("FAIL mid_reset_resp got=%0d exp=0", resps); end
    rbeat[0] = 64'hC0; rbeat[1] = 64'hC1; rbeat[2] = 64'hC2; rbeat[3] = 64'hC3;
    for (int k = 0; k < 4; k++) waits[k] = 0;
    exp_line = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
    do_burst(1'b1, 1'b0, 32'h0000_5000, '0, 32'h0000_5000);
    checks++;
    if (rdata_seen !== exp_line || lat !== 6) begin
      failures++;
      $display("FAIL post_reset_read data=%h lat=%0d exp=%h,6", rdata_seen, lat, exp_line);
    end
  endtask

  initial begin
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_address = '0; bus.mem_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
    test_reset();
    test_read();
`ifdef L2_LINE_BUFFER_EN
    test_line_buffer_hit();
`endif
    test_stray_resp();
    test_write();
    test_both_high();
    test_wait_states();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_burst_responder.md
L2_BURST_RESPONDER -- requirements
Module: l2_burst_responder

Interface
REQ-001 SHALL have parameter s_offset, default 5, byte-offset bits per line.
REQ-002 SHALL have parameter s_line, default 256, line width in bits (8*2**s_offset).
REQ-003 SHALL have parameter s_beat, default 64, memory beat width in bits; BEATS = s_line/s_beat.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports mem_read, mem_write  in  1  line read/write request from the cache arbiter, held until mem_resp.
REQ-007 SHALL have ports mem_address  in  32 and mem_wdata  in  s_line: request address and write line.
REQ-008 SHALL have ports mem_resp  out  1 and mem_rdata  out  s_line: one-cycle completion pulse and read line.
REQ-009 SHALL have ports pmem_read, pmem_write  out  1 and pmem_address  out  32: burst request to physical memory.
REQ-010 SHALL have ports pmem_wdata  out  s_beat, pmem_rdata  in  s_beat, pmem_resp  in  1 (one pulse per accepted beat).

Function
REQ-011 SHALL implement states IDLE, RD_BURST, WR_BURST, RESP.
REQ-012 IDLE: mem_write=1 -> WR_BURST; else mem_read=1 -> RD_BURST; both high -> write wins, read ignored.
REQ-013 SHALL latch {mem_address[31:s_offset], s_offset'b0} on the IDLE->burst edge; pmem_address SHALL hold it for the entire burst.
REQ-014 SHALL assert pmem_read (pmem_write) throughout RD_BURST (WR_BURST), starting the cycle after the request is seen.
REQ-015 SHALL count beats 0..BEATS-1 on pmem_resp; beat k maps to line bits [k*s_beat +: s_beat].
REQ-016 WR_BURST: pmem_wdata SHALL present beat k of the write line latched at request time.
REQ-017 RD_BURST: each pmem_resp SHALL capture pmem_rdata into beat k of the line register.
REQ-018 On pmem_resp for beat BEATS-1 SHALL go to RESP; counter wraps to 0.
REQ-019 RESP: mem_resp=1 for exactly one cycle, mem_rdata valid (complete line) that cycle; next state IDLE.
REQ-020 mem_rdata SHALL hold the last read line until the next read completes.
REQ-021 Minimum latency, request to mem_resp = BEATS+2 cycles with zero-wait pmem (6 for defaults).
REQ-022 pmem_resp outside a burst SHALL be ignored; request changes mid-burst SHALL be ignored.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, beat counter 0, mem_resp/pmem_read/pmem_write 0, pmem_address 0, mem_rdata 0.
REQ-024 Reset mid-burst SHALL abandon the burst with no mem_resp; first request after release starts a fresh burst at beat 0.

Configuration
REQ-025 Macro L2_LINE_BUFFER_EN defined: keep a valid bit plus tag of the last line read or written.
REQ-026 With it: a read in IDLE matching a valid tag SHALL go directly to RESP (mem_resp 1 cycle after request) with no pmem access; a write SHALL update the buffered line and tag after its burst.
REQ-027 Without it: every request SHALL perform a full pmem burst; no valid bit or tag storage exists.

Structure
REQ-028 SHALL put the state enum, BEATS and the default widths in shared package l2_burst_pkg.
REQ-029 SHALL instantiate one sub-module line_assembler: s_line register with per-beat load enable and beat index.

Verification
REQ-030 Read 0x0000_1234, pmem beats 0x11..,0x22..,0x33..,0x44.. zero-wait -> pmem_address 0x0000_1220, mem_resp at cycle 6, mem_rdata = {0x44..,0x33..,0x22..,0x11..}.
REQ-031 Write 0x0000_0040, wdata {D3,D2,D1,D0} -> pmem_write 4 beats, pmem_wdata D0,D1,D2,D3, single mem_resp.
REQ-032 mem_read and mem_write both high -> WR_BURST only, no pmem_read seen.
REQ-033 rst_n low after beat 2 of a read -> pmem_read drops immediately, no mem_resp; next read starts at beat 0.
REQ-034 Random 0-3 wait cycles between pmem_resp beats -> line still assembled in order, mem_resp once.
REQ-035 With L2_LINE_BUFFER_EN, repeat read of 0x0000_1220 -> mem_resp 1 cycle after request, pmem_read never asserted.
